// File: rtl/divider_pkg.sv
// Shared constants and types for the restoring divider.
package divider_pkg;

  // Default operand widths: 8-bit dividend/quotient, 4-bit divisor/remainder.
  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Iteration counter width for a DW-bit dividend.
  function automatic int cnt_width(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/restoring_divider_if.sv
// Start/ready/done handshake bundle for the restoring divider.
// Optional feature macro: DIVIDER_ZERO_CHECK_EN adds the dbz flag.
interface restoring_divider_if
  import divider_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
);

  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          ready;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
`ifdef DIVIDER_ZERO_CHECK_EN
  logic          dbz;
`endif

  // Upstream controller side.
  modport master (
    output start, dividend, divisor,
    input  ready, done, quotient, remainder
`ifdef DIVIDER_ZERO_CHECK_EN
    , input dbz
`endif
  );

  // Divider side.
  modport slave (
    input  start, dividend, divisor,
    output ready, done, quotient, remainder
`ifdef DIVIDER_ZERO_CHECK_EN
    , output dbz
`endif
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted
// partial remainder and keep the difference only when no borrow occurs.
module div_step
  import divider_pkg::*;
#(
  parameter int VW = VW_DEF
) (
  input  logic [VW:0]   r_in,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] r_out,
  output logic          q_bit
);

  logic [VW:0]   carry;
  logic [VW-1:0] diff;

  // r_in - divisor as r_in + ~divisor + 1; carry-out set means no borrow.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < VW; i++) begin : g_sub
    full_adder u_fa (
      .a    (r_in[i]),
      .b    (~divisor[i]),
      .cin  (carry[i]),
      .s    (diff[i]),
      .cout (carry[i+1])
    );
  end

  // The divisor's extended MSB is 0 (inverted: 1), so the top stage reduces
  // to an OR for the carry-out. Its sum bit is always 0 after a successful
  // subtraction, and the kept remainder is below the divisor, so the next R
  // fits in VW bits.
  assign q_bit = r_in[VW] | carry[VW];
  assign r_out = q_bit ? diff : r_in[VW-1:0];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell used to build ripple arithmetic.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional feature macro: DIVIDER_ZERO_CHECK_EN short-circuits a zero divisor
// straight to DONE and raises dbz for that done pulse.
module restoring_divider
  import divider_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic clk,
  input  logic rst,
  restoring_divider_if.slave bus
);

  localparam int CW = cnt_width(DW);

  state_e        state_q, state_d;
  logic [DW-1:0] dvd_q, dvd_d;   // dividend shifts out MSB-first, quotient shifts in
  logic [VW-1:0] dvs_q, dvs_d;
  logic [VW-1:0] rem_q, rem_d;   // partial remainder R (always < divisor)
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] remo_q, remo_d;
`ifdef DIVIDER_ZERO_CHECK_EN
  logic          dbz_q, dbz_d;
`endif

  logic          accept;
  logic          last_iter;
  logic          zero_div;
  logic [VW:0]   r_shift;
  logic [VW-1:0] r_next;
  logic          q_bit;

  assign accept    = (state_q == IDLE) && bus.start;
  assign last_iter = (cnt_q == CW'(DW - 1));
  assign r_shift   = {rem_q, dvd_q[DW-1]};

`ifdef DIVIDER_ZERO_CHECK_EN
  assign zero_div = (bus.divisor == '0);
`else
  assign zero_div = 1'b0;
`endif

  div_step #(.VW(VW)) u_step (
    .r_in    (r_shift),
    .divisor (dvs_q),
    .r_out   (r_next),
    .q_bit   (q_bit)
  );

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = zero_div ? DONE : BUSY;
      BUSY:    if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: load at accept, iterate while busy, publish on the last step.
  always_comb begin
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    remo_d = remo_q;
`ifdef DIVIDER_ZERO_CHECK_EN
    dbz_d  = dbz_q;
`endif
    if (accept) begin
      dvd_d = bus.dividend;
      dvs_d = bus.divisor;
      rem_d = '0;
      cnt_d = '0;
`ifdef DIVIDER_ZERO_CHECK_EN
      dbz_d = zero_div;
      if (zero_div) begin
        quo_d  = '1;
        remo_d = bus.dividend[VW-1:0];
      end
`endif
    end else if (state_q == BUSY) begin
      dvd_d = {dvd_q[DW-2:0], q_bit};
      rem_d = r_next;
      cnt_d = cnt_q + CW'(1);
      if (last_iter) begin
        quo_d  = {dvd_q[DW-2:0], q_bit};
        remo_d = r_next;
      end
    end
  end

  // Datapath registers; reset clears operands and results so an aborted
  // division leaves nothing visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      quo_q  <= '0;
      remo_q <= '0;
`ifdef DIVIDER_ZERO_CHECK_EN
      dbz_q  <= 1'b0;
`endif
    end else begin
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      remo_q <= remo_d;
`ifdef DIVIDER_ZERO_CHECK_EN
      dbz_q  <= dbz_d;
`endif
    end
  end

  // Outputs decoded from the registered state and result registers.
  always_comb begin
    bus.ready     = (state_q == IDLE);
    bus.done      = (state_q == DONE);
    bus.quotient  = quo_q;
    bus.remainder = remo_q;
`ifdef DIVIDER_ZERO_CHECK_EN
    bus.dbz       = dbz_q && (state_q == DONE);
`endif
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed vectors with literal
// expectations plus a cycle-level arithmetic model compared every cycle.
module tb_restoring_divider;

  localparam int DW = 8;
  localparam int VW = 4;
`ifdef DIVIDER_ZERO_CHECK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  restoring_divider_if #(.DW(DW), .VW(VW)) bus ();

  restoring_divider #(.DW(DW), .VW(VW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks edges since accept: results appear DW edges after accept (0 for a
  // checked zero divisor), the block idles again on the edge after that.
  int            edge_n    = 0;
  int            due       = 0;
  int            last_acc  = 0;
  bit            pending   = 1'b0;
  bit            mdl_valid = 1'b0;
  bit            b2b_mode  = 1'b0;
  bit            b2b_prev  = 1'b0;
  int            b2b_accepts = 0;
  bit            cur_zero  = 1'b0;
  logic [DW-1:0] exp_q, held_q = '0;
  logic [VW-1:0] exp_r, held_r = '0;

  always @(posedge clk) begin
    bit was_idle;
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    edge_n++;
    if (rst) begin
      pending   = 1'b0;
      held_q    = '0;
      held_r    = '0;
      b2b_prev  = 1'b0;
      mdl_valid = 1'b1;
    end else begin
      was_idle = !pending;
      if (pending && edge_n == due + 1) pending = 1'b0;
      if (was_idle && bus.start === 1'b1) begin
        a = bus.dividend;
        b = bus.divisor;
        cur_zero = (b == '0);
        if (cur_zero) begin
          exp_q = '1;
          exp_r = a[VW-1:0];
        end else begin
          exp_q = DW'(a / b);
          exp_r = VW'(a % b);
        end
        due = edge_n + ((ZCHK && cur_zero) ? 0 : DW);
        if (b2b_mode && b2b_prev) check("b2b_spacing", 32'(edge_n - last_acc), 32'(DW + 2));
        if (b2b_mode) b2b_accepts++;
        b2b_prev = b2b_mode;
        last_acc = edge_n;
        pending  = 1'b1;
      end
      if (pending && edge_n == due) begin
        held_q = exp_q;
        held_r = exp_r;
      end
    end
  end

  // Compare process: every cycle, handshake and held results against the model.
  always @(negedge clk) begin
    bit exp_done;
    if (mdl_valid) begin
      exp_done = pending && (edge_n == due);
      check("ready", 32'(bus.ready), 32'(!pending));
      check("done", 32'(bus.done), 32'(exp_done));
      check("quotient", 32'(bus.quotient), 32'(held_q));
      check("remainder", 32'(bus.remainder), 32'(held_r));
`ifdef DIVIDER_ZERO_CHECK_EN
      check("dbz", 32'(bus.dbz), 32'(exp_done && cur_zero));
`endif
    end
  end

  // ---------------- stimulus ----------------
  // Wait for ready, present one request, then wait for done. Returns the
  // latency in cycles counted from the accept cycle to the done cycle.
  task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b, output int lat);
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (bus.ready !== 1'b1) check("ready_timeout", 32'(bus.ready), 32'd1);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.dividend = ~a;   // operand changes after accept must not matter
    bus.divisor  = ~b;
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      bus.start = (n == 2);   // stray request while busy, must be ignored
      @(posedge clk); #1; n++;
    end
    bus.start = 1'b0;
    if (bus.done !== 1'b1) check("done_timeout", 32'(bus.done), 32'd1);
    lat = n + 1;
  endtask

  task automatic run_div(input logic [DW-1:0] a, input logic [VW-1:0] b,
                         input logic [DW-1:0] eq, input logic [VW-1:0] er,
                         input int elat, input bit edbz);
    int lat;
    issue(a, b, lat);
    check("lat", 32'(lat), 32'(elat));
    check("lit_q", 32'(bus.quotient), 32'(eq));
    check("lit_r", 32'(bus.remainder), 32'(er));
`ifdef DIVIDER_ZERO_CHECK_EN
    check("lit_dbz", 32'(bus.dbz), 32'(edbz));
`else
    if (edbz) check("lit_dbz_unexpected", 32'(edbz), 32'd0);
`endif
    @(posedge clk); #1;
    check("ready_after", 32'(bus.ready), 32'd1);
    check("done_after", 32'(bus.done), 32'd0);
  endtask

  initial begin
    int lat;
    int n;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_q", 32'(bus.quotient), 32'd0);
    check("rst_r", 32'(bus.remainder), 32'd0);
`ifdef DIVIDER_ZERO_CHECK_EN
    check("rst_dbz", 32'(bus.dbz), 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors with hand-computed results.
    run_div(8'd200, 4'd7, 8'd28, 4'd4, 9, 1'b0);
    run_div(8'd255, 4'd1, 8'd255, 4'd0, 9, 1'b0);
    run_div(8'd5, 4'd9, 8'd0, 4'd5, 9, 1'b0);
    run_div(8'd0, 4'd3, 8'd0, 4'd0, 9, 1'b0);
`ifdef DIVIDER_ZERO_CHECK_EN
    run_div(8'hA5, 4'd0, 8'hFF, 4'h5, 1, 1'b1);
    run_div(8'd17, 4'd5, 8'd3, 4'd2, 9, 1'b0);   // dbz back to 0
`else
    run_div(8'hA5, 4'd0, 8'hFF, 4'h5, 9, 1'b0);
`endif

    // Start held high, operands changing every cycle.
    b2b_mode = 1'b1;
    bus.start = 1'b1;
    for (int i = 0; i < 45; i++) begin
      bus.dividend = DW'(i * 37 + 11);
      bus.divisor  = VW'(1 + (i % 15));
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    b2b_mode  = 1'b0;
    check("b2b_accepts", 32'(b2b_accepts), 32'd5);
    n = 0;
    while (bus.ready !== 1'b1 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    check("b2b_drain", 32'(bus.ready), 32'd1);

    // Reset at iteration 4 aborts and clears everything.
    bus.dividend = 8'd77;
    bus.divisor  = 4'd5;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_q", 32'(bus.quotient), 32'd0);
    check("abort_r", 32'(bus.remainder), 32'd0);
    run_div(8'd100, 4'd10, 8'd10, 4'd0, 9, 1'b0);

    // Exhaustive nonzero-divisor sweep; the compare process checks results.
    for (int a = 0; a < 256; a++)
      for (int b = 1; b < 16; b++)
        issue(DW'(a), VW'(b), lat);

    // Every 4x4 product divides back to its factors.
    for (int x = 0; x < 16; x++)
      for (int y = 1; y < 16; y++) begin
        issue(DW'(x * y), VW'(y), lat);
        check("mul_inv_q", 32'(bus.quotient), 32'(x));
        check("mul_inv_r", 32'(bus.remainder), 32'd0);
      end

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
